// File: rtl/sysid_pkg.sv
// -----------------------------------------------------------------------------
// sysid_pkg
// Shared definitions for the system-ID register file: the Avalon-MM word map,
// CTRL register bit positions and a byte-lane merge helper.
// -----------------------------------------------------------------------------
package sysid_pkg;

    // Word addresses of the register map; address 7 is reserved and has no
    // entry, it decodes to "reads 0, writes ignored".
    typedef enum logic [2:0] {
        ADDR_ID        = 3'd0,
        ADDR_TIMESTAMP = 3'd1,
        ADDR_VERSION   = 3'd2,
        ADDR_SCRATCH   = 3'd3,
        ADDR_UPTIME_LO = 3'd4,
        ADDR_UPTIME_HI = 3'd5,
        ADDR_CTRL      = 3'd6
    } sysid_addr_e;

    // CTRL bit positions: bit0 is a write-only one-shot clear, bit1 the
    // stored freeze flag.
    localparam int CTRL_CLEAR_BIT  = 0;
    localparam int CTRL_FREEZE_BIT = 1;

    // Replace only the bytes of old_v whose byteenable lane is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sysid_uptime_cnt.sv
// -----------------------------------------------------------------------------
// sysid_uptime_cnt
// Free-running uptime counter with freeze, one-shot clear and a high-word
// shadow that is captured whenever the low word is read, so a LO-then-HI
// read pair always returns one coherent counter value.
//
// Ports
//   clk, reset_n   clock, asynchronous active-low reset
//   ctrl_wr        CTRL register write strobe (already address-decoded)
//   clear_in       CTRL write data clear bit (acts only with ctrl_wr)
//   freeze_in      CTRL write data freeze bit (stored on ctrl_wr)
//   lo_rd          accepted read of UPTIME_LO this cycle
//   cnt_lo         live counter bits [31:0]
//   hi_shadow      counter bits [CNT_W-1:32] captured at the last LO read
//   freeze         stored freeze flag
// -----------------------------------------------------------------------------
module sysid_uptime_cnt #(
    parameter int CNT_W = 48
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ctrl_wr,
    input  logic        clear_in,
    input  logic        freeze_in,
    input  logic        lo_rd,
    output logic [31:0] cnt_lo,
    output logic [31:0] hi_shadow,
    output logic        freeze
);

    logic [CNT_W-1:0] cnt;
    logic             clear;

    assign clear  = ctrl_wr & clear_in;
    assign cnt_lo = cnt[31:0];

    // Clear beats both freeze and increment; the freeze flag written in the
    // same cycle only governs the following cycles.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values of the others (the LO read sees the
    // pre-increment count).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!freeze) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            freeze <= 1'b0;
        end else if (ctrl_wr) begin
            freeze <= freeze_in;
        end
    end

    // Shifting then truncating to 32 bits zero-extends the upper counter bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_shadow <= '0;
        end else if (clear) begin
            hi_shadow <= '0;
        end else if (lo_rd) begin
            hi_shadow <= 32'(cnt >> 32);
        end
    end

endmodule

// File: rtl/sysid_regfile.sv
// -----------------------------------------------------------------------------
// sysid_regfile
// Avalon-MM slave exposing build identification words, a byte-writable
// scratch register and (optionally) an uptime counter with CTRL register.
// Fixed read latency of one cycle, no waitrequest.
//
// Optional feature: define SYSID_UPTIME_EN to build the uptime counter
// (words 4..6). Without it those words read 0 and ignore writes.
//
// Ports
//   clk, reset_n    clock, asynchronous active-low reset
//   address[2:0]    word address
//   read, write     strobes; a simultaneous read is dropped in favour of write
//   writedata[31:0] write data
//   byteenable[3:0] write byte lanes
//   readdata[31:0]  registered read data, 0 when not valid
//   readdatavalid   one-cycle qualifier for readdata
// -----------------------------------------------------------------------------
module sysid_regfile
    import sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID    = 32'h0000_5353,
    parameter logic [31:0] TIMESTAMP    = 32'h0,
    parameter logic [31:0] VERSION      = 32'h0001_0000,
    parameter int          CNT_W        = 48,
    parameter logic [31:0] SCRATCH_INIT = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    if (CNT_W < 33 || CNT_W > 64) begin : g_cnt_w_check
        $error("sysid_regfile: CNT_W must lie within 33..64");
    end

    logic        rd_acc;
    logic [31:0] scratch;
    logic [31:0] rd_mux;

    // A write always wins; the concurrent read produces no response.
    assign rd_acc = read & ~write;

    // NOTE: configuration registers get an explicit reset value; SCRATCH_INIT
    // is restored asynchronously like every other flop in the block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scratch <= SCRATCH_INIT;
        end else if (write && address == ADDR_SCRATCH) begin
            scratch <= merge_bytes(scratch, writedata, byteenable);
        end
    end

`ifdef SYSID_UPTIME_EN
    logic        ctrl_wr;
    logic        lo_rd;
    logic [31:0] up_lo;
    logic [31:0] up_hi;
    logic        freeze;
    logic [31:0] ctrl_word;

    assign ctrl_wr = write && address == ADDR_CTRL;
    assign lo_rd   = rd_acc && address == ADDR_UPTIME_LO;

    sysid_uptime_cnt #(
        .CNT_W (CNT_W)
    ) u_uptime (
        .clk       (clk),
        .reset_n   (reset_n),
        .ctrl_wr   (ctrl_wr),
        .clear_in  (writedata[CTRL_CLEAR_BIT]),
        .freeze_in (writedata[CTRL_FREEZE_BIT]),
        .lo_rd     (lo_rd),
        .cnt_lo    (up_lo),
        .hi_shadow (up_hi),
        .freeze    (freeze)
    );

    // The clear bit is an action, not state, so it always reads back as 0.
    always_comb begin
        ctrl_word                  = '0;
        ctrl_word[CTRL_FREEZE_BIT] = freeze;
    end
`endif

    // NOTE: rd_mux gets a default before the case so every path assigns it
    // and no latch is inferred.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_ID:        rd_mux = SYSTEM_ID;
            ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
            ADDR_VERSION:   rd_mux = VERSION;
            ADDR_SCRATCH:   rd_mux = scratch;
`ifdef SYSID_UPTIME_EN
            ADDR_UPTIME_LO: rd_mux = up_lo;
            ADDR_UPTIME_HI: rd_mux = up_hi;
            ADDR_CTRL:      rd_mux = ctrl_word;
`endif
            default:        rd_mux = '0;
        endcase
    end

    // readdata is forced to 0 outside valid cycles so the bus never carries
    // stale register contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdatavalid <= 1'b0;
            readdata      <= '0;
        end else begin
            readdatavalid <= rd_acc;
            readdata      <= rd_acc ? rd_mux : '0;
        end
    end

endmodule

// File: doc/sysid_regfile.md
SYSID_REGFILE -- requirements
Module: sysid_regfile

Interface
REQ-001 SHALL have parameter SYSTEM_ID, 32'h0000_5353, system identifier returned at word 0.
REQ-002 SHALL have parameter TIMESTAMP, 32'h0, build timestamp (Unix seconds) returned at word 1.
REQ-003 SHALL have parameter VERSION, 32'h0001_0000, major[31:16]/minor[15:0] returned at word 2.
REQ-004 SHALL have parameter CNT_W, 48, uptime counter width; legal range 33..64.
REQ-005 SHALL have parameter SCRATCH_INIT, 32'h0, scratch register reset value.
REQ-006 SHALL have port clk, input, 1, single clock for all logic.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port address, input, 3, Avalon-MM word address.
REQ-009 SHALL have port read, input, 1, read strobe.
REQ-010 SHALL have port write, input, 1, write strobe.
REQ-011 SHALL have port writedata, input, 32, write data.
REQ-012 SHALL have port byteenable, input, 4, byte lanes for writes.
REQ-013 SHALL have port readdata, output, 32, registered read data.
REQ-014 SHALL have port readdatavalid, output, 1, one-cycle qualifier for readdata.

Function
REQ-015 SHALL map: 0 ID, 1 TIMESTAMP, 2 VERSION, 3 SCRATCH (RW), 4 UPTIME_LO, 5 UPTIME_HI, 6 CTRL, 7 reserved (reads 0).
REQ-016 SHALL have fixed read latency 1: read in cycle N -> readdatavalid=1 and readdata valid in N+1; no waitrequest.
REQ-017 SHALL drive readdata=0 whenever readdatavalid=0.
REQ-018 SHALL accept back-to-back reads, one per cycle, each with its own readdatavalid pulse.
REQ-019 SHALL apply SCRATCH writes per byteenable lane; byteenable=0 leaves SCRATCH unchanged.
REQ-020 SHALL ignore writes to addresses 0,1,2,4,5,7.
REQ-021 SHALL, when read and write are asserted together, perform the write and ignore the read (no readdatavalid).
REQ-022 SHALL increment the uptime counter by 1 every clk unless frozen; wrap from 2^CNT_W-1 to 0.
REQ-023 SHALL, on a read of UPTIME_LO, return counter[31:0] and latch counter[CNT_W-1:32] (zero-extended) into a hi-shadow in the same cycle.
REQ-024 SHALL return the hi-shadow, not the live counter, on reads of UPTIME_HI.
REQ-025 SHALL sample the pre-increment counter value when a read of UPTIME_LO coincides with an increment or wrap.
REQ-026 SHALL treat CTRL write bit0=1 as a one-shot clear (counter and hi-shadow to 0 next cycle); bit0 is not stored.
REQ-027 SHALL store CTRL bit1 as freeze (1 = counter holds); CTRL reads return {30'b0, freeze, 1'b0}.
REQ-028 SHALL give clear priority over increment and freeze in the same cycle.

Reset
REQ-029 SHALL, on reset_n low, asynchronously set readdata=0, readdatavalid=0, SCRATCH=SCRATCH_INIT, counter=0, hi-shadow=0, freeze=0.
REQ-030 SHALL drop a read in flight when reset asserts mid-transaction (no readdatavalid after release).
REQ-031 SHALL start counting on the first clk edge after reset_n deasserts.

Configuration
REQ-032 SHALL compile the uptime/CTRL feature only when macro SYSID_UPTIME_EN is defined.
REQ-033 SHALL, without SYSID_UPTIME_EN, read 0 at addresses 4-6, ignore writes there, and contain no counter flops; words 0-3 and latency unchanged.

Structure
REQ-034 SHALL take word addresses (ADDR_ID..ADDR_CTRL), CTRL bit indices and the 7-entry address enum from shared package sysid_pkg.
REQ-035 SHALL implement counter, freeze, clear and hi-shadow in one sub-module sysid_uptime_cnt, instantiated only under SYSID_UPTIME_EN.

Verification
REQ-036 SHALL verify: reset release, read addr 0,1,2 back-to-back -> readdata 32'h0000_5353, 32'h0, 32'h0001_0000 in cycles N+1..N+3, readdatavalid high three cycles.
REQ-037 SHALL verify: write 32'hA5A5_A5A5 be=4'b0101 to addr 3 (init 0) -> readback 32'h00A5_00A5; write to addr 0 -> ID unchanged.
REQ-038 SHALL verify: CNT_W=33, force counter to 33'h1_FFFF_FFFF, read addr 4 then 5 -> 32'hFFFF_FFFF then 32'h1; next UPTIME_LO read after wrap returns a small value, UPTIME_HI 0.
REQ-039 SHALL verify: write CTRL 32'h2 -> two UPTIME_LO reads 10 cycles apart equal; write CTRL 32'h3 -> next UPTIME_LO read returns 0; CTRL read returns 32'h2.
REQ-040 SHALL verify: read+write asserted together at addr 3 with 32'h1234_5678 -> no readdatavalid next cycle, later read returns 32'h1234_5678.
REQ-041 SHALL verify: reset_n pulsed low the cycle after a read -> readdatavalid stays 0, SCRATCH returns to SCRATCH_INIT.
